// File: rtl/sensor_conditioner.sv
// Input conditioning: two-flop synchronisers, per-bit debouncers with change pulses,
// and one-hot tank level decode with a persistence-filtered probe fault.
module sensor_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned FAULT_CYCLES    = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] raw,
   output logic [7:0] clean,
   output logic [7:0] changed,
   output logic [3:0] level,
   output logic       level_fault
);

   localparam int unsigned NBITS = 8;
   localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned FLT_W = (FAULT_CYCLES > 2) ? $clog2(FAULT_CYCLES) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FAULT_CYCLES - 1);

   localparam logic [3:0] LVL_VAZIO = 4'b0001;
   localparam logic [3:0] LVL_BAIXO = 4'b0010;
   localparam logic [3:0] LVL_MEDIO = 4'b0100;
   localparam logic [3:0] LVL_CHEIO = 4'b1000;

   logic [NBITS-1:0] sync1_q, sync2_q;
   logic [NBITS-1:0] clean_q, clean_d;
   logic [NBITS-1:0] changed_q, changed_d;
   logic [DB_W-1:0]  db_cnt_q [NBITS];
   logic [DB_W-1:0]  db_cnt_d [NBITS];
   logic [3:0]       level_q, level_d;
   logic             fault_q, fault_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;

   logic [2:0]       probe_pat;
   logic             pat_valid;
   logic [3:0]       pat_level;

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         clean_q   <= '0;
         changed_q <= '0;
         for (int i = 0; i < NBITS; i++) db_cnt_q[i] <= '0;
         level_q   <= LVL_VAZIO;
         fault_q   <= 1'b0;
         flt_cnt_q <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         clean_q   <= clean_d;
         changed_q <= changed_d;
         for (int i = 0; i < NBITS; i++) db_cnt_q[i] <= db_cnt_d[i];
         level_q   <= level_d;
         fault_q   <= fault_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   // Per-bit debounce: any return to the clean value discards the partial count
   always_comb begin
      clean_d   = clean_q;
      changed_d = '0;
      for (int i = 0; i < NBITS; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != clean_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               clean_d[i]   = sync2_q[i];
               changed_d[i] = 1'b1;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Probe pattern {LL, MM, HH} decode
   always_comb begin
      probe_pat = {clean_q[2], clean_q[1], clean_q[0]};
      pat_valid = 1'b1;
      pat_level = level_q;
      case (probe_pat)
         3'b000:  pat_level = LVL_VAZIO;
         3'b100:  pat_level = LVL_BAIXO;
         3'b110:  pat_level = LVL_MEDIO;
         3'b111:  pat_level = LVL_CHEIO;
         default: pat_valid = 1'b0;
      endcase
   end

   // Level holds through invalid patterns; fault counts persistence of the opposite validity
   always_comb begin
      level_d   = pat_valid ? pat_level : level_q;
      fault_d   = fault_q;
      flt_cnt_d = '0;
      if (pat_valid == fault_q) begin
         if (flt_cnt_q == FLT_LAST) begin
            fault_d = ~fault_q;
         end else begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
         end
      end
   end

   assign clean       = clean_q;
   assign changed     = changed_q;
   assign level       = level_q;
   assign level_fault = fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus pushes expected output events with
// their due cycle; a negedge monitor pops and compares every observed event.
module tb_sensor_conditioner;

   localparam int unsigned DB  = 4;
   localparam int unsigned FLT = 3;
   localparam int K_CHG = 0;
   localparam int K_LVL = 1;
   localparam int K_FLT = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic [15:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] raw = 8'hFF;
   logic [7:0] clean, changed;
   logic [3:0] level;
   logic       level_fault;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   logic [3:0] prev_level;
   logic       prev_fault;
   exp_t sb [$];

   sensor_conditioner #(.DEBOUNCE_CYCLES(DB), .FAULT_CYCLES(FLT)) dut (
      .clk(clk), .reset(reset), .raw(raw), .clean(clean),
      .changed(changed), .level(level), .level_fault(level_fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int kind, input int dly, input logic [15:0] val);
      exp_t e;
      e.cyc  = cyc + dly;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic observe(input int kind, input logic [15:0] val);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: kind %0d value %h at cycle %0d, nothing expected", kind, val, cyc);
      end else begin
         e = sb.pop_front();
         check("event_kind", 16'(kind), 16'(e.kind));
         check("event_value", val, e.val);
         check("event_cycle", 16'(cyc), 16'(e.cyc));
      end
   endtask

   // Monitor: an event is a changed pulse, a level change or a fault change
   always @(negedge clk) begin
      if (mon_en) begin
         if (changed !== 8'h00) observe(K_CHG, {clean, changed});
         if (level !== prev_level) observe(K_LVL, {12'h000, level});
         if (level_fault !== prev_fault) observe(K_FLT, {15'h0000, level_fault});
         prev_level = level;
         prev_fault = level_fault;
      end
   end

   // Raw change applied at a negedge: clean/changed due DB+2 edges later, level one more
   task automatic drive(input logic [7:0] v);
      raw = v;
   endtask

   initial begin
      // 1. Reset values, then release with all inputs high
      tick(3);
      check("reset_clean", {8'h00, clean}, 16'h0000);
      check("reset_changed", {8'h00, changed}, 16'h0000);
      check("reset_level", {12'h000, level}, 16'h0001);
      check("reset_fault", {15'h0000, level_fault}, 16'h0000);
      prev_level = 4'b0001;
      prev_fault = 1'b0;
      mon_en = 1'b1;
      push(K_CHG, DB + 2, 16'hFFFF);
      push(K_LVL, DB + 3, 16'h0008);
      reset = 1'b0;
      tick(12);

      // 2. Glitch rejection on bit 3
      drive(8'h07);
      push(K_CHG, DB + 2, {8'h07, 8'hF8});
      tick(12);
      drive(8'h0F);
      tick(3);
      drive(8'h07);
      tick(12);
      drive(8'h0F);
      push(K_CHG, DB + 2, {8'h0F, 8'h08});
      tick(4);
      drive(8'h07);
      push(K_CHG, DB + 2, {8'h07, 8'h08});
      tick(12);

      // 3. Level fill sequence from empty
      drive(8'h00);
      push(K_CHG, DB + 2, {8'h00, 8'h07});
      push(K_LVL, DB + 3, 16'h0001);
      tick(12);
      drive(8'h04);
      push(K_CHG, DB + 2, {8'h04, 8'h04});
      push(K_LVL, DB + 3, 16'h0002);
      tick(12);
      drive(8'h06);
      push(K_CHG, DB + 2, {8'h06, 8'h02});
      push(K_LVL, DB + 3, 16'h0004);
      tick(12);
      drive(8'h07);
      push(K_CHG, DB + 2, {8'h07, 8'h01});
      push(K_LVL, DB + 3, 16'h0008);
      tick(12);

      // 4. Inconsistent probes (HH only), then restore
      drive(8'h01);
      push(K_CHG, DB + 2, {8'h01, 8'h06});
      push(K_FLT, DB + 2 + FLT, 16'h0001);
      tick(12);
      check("fault_level_hold", {12'h000, level}, 16'h0008);
      drive(8'h07);
      push(K_CHG, DB + 2, {8'h07, 8'h06});
      push(K_FLT, DB + 2 + FLT, 16'h0000);
      tick(12);
      check("restored_level", {12'h000, level}, 16'h0008);

      // 5. Reset mid-debounce
      drive(8'h00);
      push(K_CHG, DB + 2, {8'h00, 8'h07});
      push(K_LVL, DB + 3, 16'h0001);
      tick(12);
      drive(8'h01);
      tick(2);
      reset = 1'b1;
      tick(2);
      check("midreset_clean", {8'h00, clean}, 16'h0000);
      reset = 1'b0;
      push(K_CHG, DB + 2, {8'h01, 8'h01});
      push(K_FLT, DB + 2 + FLT, 16'h0001);
      tick(14);
      drive(8'h00);
      push(K_CHG, DB + 2, {8'h00, 8'h01});
      push(K_FLT, DB + 2 + FLT, 16'h0000);
      tick(14);

      // 6. Simultaneous qualification of switch and agro
      drive(8'hC0);
      push(K_CHG, DB + 2, {8'hC0, 8'hC0});
      tick(12);
      drive(8'h00);
      push(K_CHG, DB + 2, {8'h00, 8'hC0});
      tick(12);

      check("scoreboard_drained", 16'(sb.size()), 16'h0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
